// File: rtl/enigma_pkg.sv
// Shared constants, FSM state type and ASCII classification helpers for the
// Enigma stage driver.
package enigma_pkg;

    localparam logic [7:0]  ASCII_A      = 8'h41;
    localparam logic [7:0]  ASCII_Z      = 8'h5A;
    localparam logic [7:0]  ASCII_LA     = 8'h61;
    localparam logic [7:0]  ASCII_LZ     = 8'h7A;
    localparam int unsigned NUM_LETTERS  = 26;
    localparam int unsigned IDX_W        = 208;
    localparam logic [7:0]  TIMEOUT_CHAR = 8'h3F;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT
    } state_t;

    function automatic logic is_upper(input logic [7:0] c);
        return (c >= ASCII_A) && (c <= ASCII_Z);
    endfunction

    function automatic logic is_lower(input logic [7:0] c);
        return (c >= ASCII_LA) && (c <= ASCII_LZ);
    endfunction

endpackage

// File: rtl/enigma_char_fifo.sv
// Synchronous show-ahead FIFO holding {dec, char} entries for the stage driver.
module enigma_char_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW + 1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when an entry leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/enigma_stage_driver.sv
// Initiator for one Enigma substitution stage: loads the wiring table, buffers
// characters, dispatches letters one at a time and returns results with a timeout.
module enigma_stage_driver #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cfg_clr,
    input  logic         cfg_wr,
    input  logic [7:0]   cfg_byte,
    output logic         cfg_ready,
    output logic         cfg_loaded,
    output logic         cfg_err,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    input  logic         in_dec,
    output logic         in_ready,
    output logic         st_set,
    output logic [207:0] st_idx,
    output logic         st_valid,
    output logic [7:0]   st_din,
    output logic         st_dec,
    input  logic [7:0]   st_dout,
    input  logic         st_done,
    output logic         out_valid,
    output logic [7:0]   out_data,
    input  logic         out_ready,
    output logic         err_timeout
);

    import enigma_pkg::*;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t             state_q;
    logic [7:0]         timer_q;
    logic [4:0]         cfg_cnt_q;
    logic               cfg_loaded_q;
    logic               cfg_err_q;
    logic               st_set_q;
    logic [IDX_W-1:0]   idx_q;
    logic               st_valid_q;
    logic [7:0]         st_din_q;
    logic               st_dec_q;
    logic               out_valid_q;
    logic [7:0]         out_data_q;
    logic               err_timeout_q;

    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic [8:0]         fifo_rdata;
    logic [7:0]         pop_char;
    logic               pop_dec;
    logic [7:0]         letter_d;
    logic               is_letter_d;
    logic               cfg_accept;

    assign cfg_ready  = (state_q == IDLE) && fifo_empty;
    assign cfg_accept = cfg_wr && cfg_ready;
    assign in_ready   = cfg_loaded_q && !fifo_full;
    assign fifo_push  = in_valid && in_ready;
    assign fifo_pop   = (state_q == IDLE) && !fifo_empty;

    assign pop_dec     = fifo_rdata[8];
    assign pop_char    = fifo_rdata[7:0];
    assign is_letter_d = is_upper(pop_char) || is_lower(pop_char);
    assign letter_d    = is_lower(pop_char) ? pop_char - (ASCII_LA - ASCII_A) : pop_char;

    enigma_char_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (fifo_push),
        .wdata_i ({in_dec, in_data}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Wiring-table loader; slot k lives at [IDX_W-1-8k -: 8].
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cfg_cnt_q    <= '0;
            cfg_loaded_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            st_set_q     <= 1'b0;
            idx_q        <= '0;
        end else begin
            st_set_q <= 1'b0;
            if (cfg_clr) begin
                cfg_cnt_q    <= '0;
                cfg_loaded_q <= 1'b0;
                cfg_err_q    <= 1'b0;
            end else if (cfg_accept) begin
                if (!is_upper(cfg_byte)) begin
                    cfg_err_q    <= 1'b1;
                    cfg_cnt_q    <= '0;
                    cfg_loaded_q <= 1'b0;
                end else begin
                    for (int unsigned k = 0; k < NUM_LETTERS; k++) begin
                        if (cfg_cnt_q == 5'(k)) begin
                            idx_q[IDX_W - 1 - 8 * k -: 8] <= cfg_byte;
                        end
                    end
                    if (cfg_cnt_q == 5'(NUM_LETTERS - 1)) begin
                        cfg_cnt_q    <= '0;
                        cfg_loaded_q <= 1'b1;
                        st_set_q     <= 1'b1;
                    end else begin
                        cfg_cnt_q    <= cfg_cnt_q + 1'b1;
                        cfg_loaded_q <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            st_valid_q    <= 1'b0;
            st_din_q      <= '0;
            st_dec_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            if (cfg_clr) begin
                err_timeout_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (is_letter_d) begin
                            st_valid_q <= 1'b1;
                            st_din_q   <= letter_d;
                            st_dec_q   <= pop_dec;
                            state_q    <= ISSUE;
                        end else begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= pop_char;
                            state_q     <= OUT;
                        end
                    end
                end
                ISSUE: begin
                    st_valid_q <= 1'b0;
                    timer_q    <= '0;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (st_done) begin
                        out_data_q  <= st_dout;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else if (timer_q == TIMER_LAST) begin
                        out_data_q    <= TIMEOUT_CHAR;
                        out_valid_q   <= 1'b1;
                        err_timeout_q <= 1'b1;
                        state_q       <= OUT;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cfg_loaded  = cfg_loaded_q;
    assign cfg_err     = cfg_err_q;
    assign st_set      = st_set_q;
    assign st_idx      = idx_q;
    assign st_valid    = st_valid_q;
    assign st_din      = st_din_q;
    assign st_dec      = st_dec_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign err_timeout = err_timeout_q;

endmodule
